// File: rtl/axi_defs_pkg.sv
// Shared AXI4 encodings and the operand-fetch FSM state type.
package axi_defs_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_CHECK = 3'd1,
        FETCH_ADDR  = 3'd2,
        FETCH_DATA  = 3'd3,
        FETCH_FIN   = 3'd4
    } fetch_state_t;

    // A read beat is healthy only when the slave reports OKAY.
    function automatic logic resp_is_okay(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/operand_fetch_controller.sv
// Operand fetch controller: on start, reads NUM_WORDS 32-bit words through an
// AXI4 read-only master in INCR bursts of BURST_LEN beats, one burst in flight
// at a time, and packs them into a flat operand bus for the LSTM datapath.
// done pulses when the buffer is complete; err pulses with it on a bad
// response, a malformed burst, or a request that would run past the top of
// the address space.
module operand_fetch_controller
    import axi_defs_pkg::*;
#(
    parameter int NUM_WORDS = 64,
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic [NUM_WORDS*32-1:0] data_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W-1:0]       m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic                    m_axi_arlock,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int NUM_BURSTS = NUM_WORDS / BURST_LEN;
    localparam int WIDX_W     = $clog2(NUM_WORDS) + 1;
    localparam int BCNT_W     = $clog2(BURST_LEN) + 1;
    localparam int BIDX_W     = $clog2(NUM_BURSTS) + 1;

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);
    localparam logic [31:0]       FETCH_BYTES = 32'(NUM_WORDS * 4);
    localparam logic [31:0]       MEM_BYTES   = 32'd1 << ADDR_W;
    localparam logic [BCNT_W-1:0] LAST_BEAT   = BCNT_W'(BURST_LEN - 1);
    localparam logic [BIDX_W-1:0] LAST_BURST  = BIDX_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK   = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Registered state and datapath
    fetch_state_t              state_r;
    logic [ADDR_W-1:0]         base_r;
    logic [WIDX_W-1:0]         word_idx_r;
    logic [BIDX_W-1:0]         burst_idx_r;
    logic [BCNT_W-1:0]         beat_cnt_r;
    logic                      err_flag_r;
    logic [NUM_WORDS*32-1:0]   data_flat_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      err_r;
    logic                      arvalid_r;
    logic                      rready_r;
    logic [ADDR_W-1:0]         araddr_r;

    // Next-state values
    fetch_state_t              state_next_s;
    logic [ADDR_W-1:0]         base_next_s;
    logic [WIDX_W-1:0]         word_idx_next_s;
    logic [BIDX_W-1:0]         burst_idx_next_s;
    logic [BCNT_W-1:0]         beat_cnt_next_s;
    logic                      err_flag_next_s;
    logic                      busy_next_s;
    logic                      done_next_s;
    logic                      err_next_s;
    logic                      arvalid_next_s;
    logic                      rready_next_s;
    logic [ADDR_W-1:0]         araddr_next_s;

    // Per-beat decode
    logic                      beat_s;
    logic                      full_s;
    logic                      burst_end_s;
    logic                      range_bad_s;
    logic [WIDX_W-2:0]         word_sel_s;

    assign range_bad_s = (32'(base_r) + FETCH_BYTES) > MEM_BYTES;
    assign full_s      = (beat_cnt_r == LAST_BEAT);
    assign burst_end_s = full_s | m_axi_rlast;
    assign word_sel_s  = word_idx_r[WIDX_W-2:0];

    // Next-state, counter and flag updates for the fetch sequence.
    always_comb begin
        state_next_s     = state_r;
        base_next_s      = base_r;
        word_idx_next_s  = word_idx_r;
        burst_idx_next_s = burst_idx_r;
        beat_cnt_next_s  = beat_cnt_r;
        err_flag_next_s  = err_flag_r;
        beat_s           = 1'b0;
        case (state_r)
            FETCH_IDLE: begin
                if (start) begin
                    base_next_s      = base_addr & WORD_MASK;
                    word_idx_next_s  = '0;
                    burst_idx_next_s = '0;
                    beat_cnt_next_s  = '0;
                    err_flag_next_s  = 1'b0;
                    state_next_s     = FETCH_CHECK;
                end else begin
                    state_next_s = FETCH_IDLE;
                end
            end
            FETCH_CHECK: begin
                // A request running past the top of memory never reaches the bus.
                if (range_bad_s) begin
                    err_flag_next_s = 1'b1;
                    state_next_s    = FETCH_FIN;
                end else begin
                    state_next_s = FETCH_ADDR;
                end
            end
            FETCH_ADDR: begin
                if (arvalid_r && m_axi_arready) begin
                    state_next_s = FETCH_DATA;
                end else begin
                    state_next_s = FETCH_ADDR;
                end
            end
            FETCH_DATA: begin
                if (m_axi_rvalid && rready_r) begin
                    beat_s          = 1'b1;
                    word_idx_next_s = word_idx_r + WIDX_W'(1);
                    beat_cnt_next_s = beat_cnt_r + BCNT_W'(1);
                    // Bad response, missing rlast on the final beat, or an early
                    // rlast all flag the request; the data is kept regardless.
                    err_flag_next_s = err_flag_r
                                    | ~resp_is_okay(m_axi_rresp)
                                    | (burst_end_s & (full_s ^ m_axi_rlast));
                    if (burst_end_s) begin
                        // A short burst still occupies its full slot in the buffer.
                        beat_cnt_next_s = '0;
                        word_idx_next_s = WIDX_W'((32'(burst_idx_r) + 32'd1) * 32'(BURST_LEN));
                        if (burst_idx_r == LAST_BURST) begin
                            state_next_s = FETCH_FIN;
                        end else begin
                            burst_idx_next_s = burst_idx_r + BIDX_W'(1);
                            state_next_s     = FETCH_ADDR;
                        end
                    end else begin
                        state_next_s = FETCH_DATA;
                    end
                end else begin
                    state_next_s = FETCH_DATA;
                end
            end
            FETCH_FIN: begin
                state_next_s = FETCH_IDLE;
            end
            default: begin
                state_next_s = FETCH_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every
    // port comes straight from a flop.
    always_comb begin
        busy_next_s    = (state_next_s == FETCH_CHECK) ||
                         (state_next_s == FETCH_ADDR)  ||
                         (state_next_s == FETCH_DATA);
        done_next_s    = (state_next_s == FETCH_FIN);
        err_next_s     = (state_next_s == FETCH_FIN) && err_flag_next_s;
        arvalid_next_s = (state_next_s == FETCH_ADDR);
        rready_next_s  = (state_next_s == FETCH_DATA);
        if (state_next_s == FETCH_ADDR) begin
            araddr_next_s = base_next_s + ADDR_W'(burst_idx_next_s) * BURST_BYTES;
        end else begin
            araddr_next_s = araddr_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, flags and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_r      <= '0;
            word_idx_r  <= '0;
            burst_idx_r <= '0;
            beat_cnt_r  <= '0;
            err_flag_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            araddr_r    <= '0;
        end else begin
            base_r      <= base_next_s;
            word_idx_r  <= word_idx_next_s;
            burst_idx_r <= burst_idx_next_s;
            beat_cnt_r  <= beat_cnt_next_s;
            err_flag_r  <= err_flag_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
            arvalid_r   <= arvalid_next_s;
            rready_r    <= rready_next_s;
            araddr_r    <= araddr_next_s;
        end
    end

    // Operand buffer: each accepted beat lands in its word slot; the buffer is
    // otherwise held so results stay stable between requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_flat_r <= '0;
        end else if (beat_s) begin
            data_flat_r[32*word_sel_s +: 32] <= m_axi_rdata;
        end else begin
            data_flat_r <= data_flat_r;
        end
    end

    assign data_flat     = data_flat_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_operand_fetch_controller.sv
// Scoreboard bench for operand_fetch_controller: a behavioural AXI slave with
// optional random stalls and SLVERR injection, a reference model that computes
// expected buffers straight from the memory image, and monitors that compare
// AR requests and done/err/data_flat against queued expectations.
module tb_operand_fetch_controller;

    localparam int NW = 64;
    localparam int BL = 16;
    localparam int AW = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [NW*32-1:0]  data_flat;
    logic              busy, done, err;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic              arlock;
    logic [2:0]        arprot;
    logic              arvalid, arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    operand_fetch_controller #(.NUM_WORDS(NW), .BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .data_flat(data_flat), .busy(busy), .done(done), .err(err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arlock(arlock),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NW*32-1:0] data;
        logic             err;
        int               lat;
        int               t0;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] ar_q[$];
    logic [31:0]   mem [0:1023];
    logic [NW*32-1:0] model_data;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  ar_hs_cnt = 0;
    int  r_hs_cnt = 0;
    bit  stall_en = 1'b0;
    int  slv_err_burst = -1;
    int  slv_burst_cnt = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AXI read slave: one burst at a time, optional random stalls,
    // SLVERR on beat 5 of the selected burst.
    initial begin : slave
        bit            ar_hs, r_hs, rst_low;
        bit            act;
        logic [AW-1:0] sa, ap;
        int            beat;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
        act = 1'b0; beat = 0; sa = '0;
        forever begin
            @(negedge clk);
            rst_low = !rst_n;
            ar_hs   = rst_n && arvalid && arready;
            r_hs    = rst_n && rvalid && rready;
            ap      = araddr;
            @(posedge clk);
            #1;
            if (rst_low) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; act = 1'b0; beat = 0;
            end else begin
                if (r_hs) begin
                    rvalid = 1'b0;
                    beat++;
                    if (beat == BL) act = 1'b0;
                end
                if (ar_hs) begin
                    act = 1'b1; sa = ap; beat = 0; arready = 1'b0;
                    slv_burst_cnt++;
                end
                if (!act) arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
                if (act && !rvalid) begin
                    if (!stall_en || $urandom_range(0, 2) != 0) begin
                        rvalid = 1'b1;
                        rdata  = mem[(int'(sa) >> 2) + beat];
                        rresp  = (slv_burst_cnt == slv_err_burst && beat == 4) ? 2'b10 : 2'b00;
                        rlast  = (beat == BL - 1);
                    end
                end
            end
        end
    end

    // AR channel monitor: request order/attributes, stability under backpressure.
    bit            ar_pend = 1'b0;
    logic [AW-1:0] ar_pend_addr;
    logic [AW-1:0] ar_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            ar_pend = 1'b0;
        end else begin
            if (rvalid && rready) r_hs_cnt++;
            if (ar_pend)
                chk(arvalid === 1'b1 && araddr === ar_pend_addr, "ar_stable",
                    {arvalid, araddr}, {1'b1, ar_pend_addr});
            if (arvalid === 1'b1) begin
                if (arready) begin
                    ar_hs_cnt++;
                    ar_pend = 1'b0;
                    if (ar_q.size() == 0) begin
                        chk(1'b0, "unexpected_ar", araddr, 0);
                    end else begin
                        ar_exp = ar_q.pop_front();
                        chk(araddr === ar_exp, "araddr", araddr, ar_exp);
                        chk(arlen === 8'd15 && arsize === 3'b010 && arburst === 2'b01, "ar_attrs",
                            {arlen, arsize, arburst}, {8'd15, 3'b010, 2'b01});
                        chk({arcache, arlock, arprot} === 8'd0, "ar_const",
                            {arcache, arlock, arprot}, 0);
                    end
                end else begin
                    ar_pend = 1'b1;
                    ar_pend_addr = araddr;
                end
            end else begin
                ar_pend = 1'b0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done.
    exp_t mon_e;
    int   bad_w;
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk(1'b0, "unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk(err === mon_e.err, "err", err, mon_e.err);
                chk(busy === 1'b0, "busy_at_done", busy, 0);
                bad_w = -1;
                for (int i = 0; i < NW; i++)
                    if (bad_w < 0 && data_flat[i*32 +: 32] !== mon_e.data[i*32 +: 32]) bad_w = i;
                if (bad_w < 0)
                    chk(1'b1, "data_flat", 0, 0);
                else
                    chk(1'b0, $sformatf("data_flat_w%0d", bad_w),
                        data_flat[bad_w*32 +: 32], mon_e.data[bad_w*32 +: 32]);
                if (mon_e.lat >= 0)
                    chk(cyc - mon_e.t0 == mon_e.lat, "latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        sb_q.delete();
        ar_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_data = '0;
        @(negedge clk);
        chk(data_flat === '0, "rst_data_flat", data_flat[63:0], 0);
        chk(busy === 1'b0, "rst_busy", busy, 0);
        chk(done === 1'b0, "rst_done", done, 0);
        chk(err === 1'b0, "rst_err", err, 0);
        chk(arvalid === 1'b0, "rst_arvalid", arvalid, 0);
        chk(rready === 1'b0, "rst_rready", rready, 0);
        chk(araddr === '0, "rst_araddr", araddr, 0);
    endtask

    // Reference model: expected buffer, AR sequence, err and latency from the
    // request parameters and the memory image.
    task automatic issue_fetch(input logic [AW-1:0] base, input int err_burst, input bit stall,
                               output bit bad);
        exp_t e;
        int   b;
        b   = int'(base) & ~3;
        bad = (b + NW * 4) > 4096;
        e.data = model_data;
        if (!bad) begin
            for (int i = 0; i < NW; i++) e.data[i*32 +: 32] = mem[b/4 + i];
            for (int k = 0; k < NW / BL; k++) ar_q.push_back(AW'(b + k * BL * 4));
        end
        e.err = bad || (err_burst >= 1);
        e.lat = bad ? 2 : (stall ? -1 : 2 + (NW / BL) * (1 + BL));
        model_data    = e.data;
        slv_err_burst = err_burst;
        stall_en      = stall;
        slv_burst_cnt = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        e.t0      = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk(busy === 1'b1, "busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk(1'b0, "done_timeout", n, budget);
            sb_q.delete();
            ar_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(input logic [AW-1:0] base, input int err_burst, input bit stall);
        bit bad;
        int ar0, r0;
        ar0 = ar_hs_cnt;
        r0  = r_hs_cnt;
        issue_fetch(base, err_burst, stall, bad);
        wait_done(4000);
        chk(ar_q.size() == 0, "ar_count", ar_q.size(), 0);
        chk(ar_hs_cnt - ar0 == (bad ? 0 : NW / BL), "ar_handshakes", ar_hs_cnt - ar0, bad ? 0 : NW / BL);
        chk(r_hs_cnt - r0 == (bad ? 0 : NW), "r_beats", r_hs_cnt - r0, bad ? 0 : NW);
    endtask

    initial begin : stim
        bit dummy;
        int t0, d0, eb;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; model_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < NW; i++) mem[64 + i] = 32'hB000_0000 + 32'(i);

        do_reset();

        // Directed: zero-wait fetch, stalled fetch, out-of-range, SLVERR
        run_fetch(12'h100, -1, 1'b0);
        run_fetch(12'h100, -1, 1'b1);
        run_fetch(12'hF04, -1, 1'b0);
        run_fetch(12'hF00, -1, 1'b0);
        run_fetch(12'h100, 2, 1'b0);

        // Reset in the middle of the first burst, then a fresh request
        issue_fetch(12'h100, -1, 1'b0, dummy);
        repeat (6) @(posedge clk);
        do_reset();
        run_fetch(12'h200, -1, 1'b0);

        // start pulses during the fetch and in the done cycle are ignored
        d0 = done_cnt;
        issue_fetch(12'h300, -1, 1'b0, dummy);
        t0 = sb_q[0].t0;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 12'h000;
        @(posedge clk);
        #1;
        start = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t0 + 69);
        start = 1'b1; base_addr = 12'h400;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk(done_cnt - d0 == 1, "done_once", done_cnt - d0, 1);
        chk(busy === 1'b0, "idle_after_ignored_start", busy, 0);
        chk(sb_q.size() == 0, "sb_drained", sb_q.size(), 0);

        // Randomised requests, stall patterns and error injection
        for (int k = 0; k < 8; k++) begin
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_fetch(AW'($urandom_range(0, 4095)), eb, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk(sb_q.size() == 0, "final_sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
